mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage data-memory controller for the 5-stage RV32I pipeline, sitting between the EX/MEM and MEM/WB pipeline registers. It takes the load/store decoded in EX/MEM and drives a request/grant/response data-memory bus. It builds byte enables and lane-replicated store data, and aligns and sign-extends load data. While the access is outstanding it holds the whole pipeline through `mem_stall`.

## Interface
Parameters:
- `XLEN`, 32: data/address width; only 32 is supported.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; same reset as the pipeline registers.
- `addr_in`  in  XLEN  effective address (EX/MEM `alu_result_out`).
- `store_data_in`  in  XLEN  EX/MEM `rs2_data_out`.
- `MemRead_in`, `MemWrite_in`  in  1 each  access type from EX/MEM; both high is treated as a read.
- `funct3_in`  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 are treated as W.
- `hold_in`  in  1  stall from another source; keeps the completed result presented.
- `dmem_req`  out  1  request valid (registered).
- `dmem_we`  out  1  1 = store.
- `dmem_addr`  out  XLEN  word address; `addr_in` with bits [1:0] forced to 0.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  XLEN  store data replicated across lanes.
- `dmem_gnt`  in  1  request accepted this cycle.
- `dmem_rvalid`  in  1  response/completion; one pulse per granted request, for stores too.
- `dmem_rdata`  in  XLEN  read word, valid with `dmem_rvalid`.
- `load_data`  out  XLEN  aligned, extended load result (registered), to MEM/WB `mem_data_in`.
- `mem_stall`  out  1  combinational; drives stall on all pipeline registers.
- `misalign_fault`  out  1  misaligned access detected (`MISALIGN_TRAP_EN` only).

## Operation
- FSM states and transitions:
  - IDLE: if an access is pending (`MemRead_in|MemWrite_in`), latch request fields and go to REQ.
  - REQ: `dmem_req`=1, outputs held stable until `dmem_gnt`; on gnt go to WAIT.
  - WAIT: wait for `dmem_rvalid`; on rvalid capture the extended data into `load_data` and go to DONE.
  - DONE: result presented. If `hold_in`=0, go to IDLE; else stay in DONE.
- `mem_stall` = (IDLE & access pending) | REQ | WAIT. It is 0 in DONE, so the pipeline advances on the DONE cycle.
- In IDLE with no access: `mem_stall`=0, no request.
- Byte enables and store data:
  - B: `dmem_be` = 0001 << addr[1:0]; data byte replicated ×4.
  - H: `dmem_be` = 0011 << {addr[1],1'b0}; data halfword replicated ×2.
  - W: `dmem_be` = 1111.
  - Loads drive `dmem_be` the same way; `dmem_wdata` is don't-care on loads.
- Load extraction selects the lane by addr[1:0] (B) or addr[1] (H), then zero-extends for BU/HU and sign-extends for B/H. The result is stored in `load_data` and held until the next completed load. Stores leave `load_data` unchanged.
- `dmem_gnt` or `dmem_rvalid` outside REQ/WAIT is ignored. `dmem_gnt` and `dmem_rvalid` in the same cycle while in REQ: gnt is taken, and rvalid is not counted.

## Timing
- Reset values:
  - Outputs: `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_be`=0, `dmem_wdata`=0, `load_data`=0, `misalign_fault`=0.
  - State: IDLE; `mem_stall` follows IDLE decode.
- Minimum access time: IDLE → REQ → WAIT → DONE = 3 stall cycles, with gnt in the first REQ cycle and rvalid the cycle after.
- Each cycle of gnt delay or rvalid delay adds one stall cycle. There is no timeout.
- Reset mid-access: the unit returns to IDLE immediately and `dmem_req` drops asynchronously. The memory shares `reset`, so no stale response arrives.
- After DONE→IDLE, a back-to-back access sees the new EX/MEM contents in IDLE on the next cycle.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - Misaligned accesses are detected: H with addr[0]≠0, W with addr[1:0]≠0.
  - On detection in IDLE, no request is issued, `mem_stall` stays 0, and `misalign_fault` pulses for exactly that one cycle. It is registered, so it is visible on the following cycle.
  - `load_data` is unchanged.
- `MISALIGN_TRAP_EN` not defined:
  - No misalignment check; the access proceeds with the enables computed above, using addr[1] for H and ignoring addr[1:0] for W.
  - `misalign_fault` is tied to 0.

## Test plan
- LW addr 0x100, gnt in 1st REQ cycle, rvalid next cycle, rdata 0xDEADBEEF → `dmem_addr`=0x100, `dmem_be`=1111, `mem_stall` high for exactly 3 cycles, `load_data`=0xDEADBEEF in DONE.
- LB addr 0x103 and LBU addr 0x103, rdata 0x80FF_0000 → `dmem_be`=1000; `load_data` = 0xFFFFFF80 for LB and 0x00000080 for LBU.
- SH addr 0x202, data 0x1234ABCD → `dmem_we`=1, `dmem_be`=1100, `dmem_wdata`=0xABCDABCD; gnt delayed 3 cycles → `dmem_req` stays high and outputs stay stable, stall = 6 cycles.
- LW completes with `hold_in`=1 for 2 cycles → FSM stays in DONE, no second request, `load_data` stable; exits to IDLE when `hold_in` drops.
- Assert `reset` while in WAIT → `dmem_req`=0, state IDLE, `load_data`=0 the same cycle.
- With `MISALIGN_TRAP_EN`: LW addr 0x101 → no `dmem_req`, `mem_stall`=0, `misalign_fault`=1 for one cycle. Without the macro: the access issues to 0x100 with `dmem_be`=1111.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory controller for the RV32I pipeline.
//
// Takes the load/store held in EX/MEM and issues it on a req/gnt/rvalid data-memory bus. It
// builds byte enables and lane-replicated store data, then aligns and sign/zero-extends load
// data into a registered result. The whole pipeline is held on mem_stall while an access is
// outstanding. The stall drops in DONE, so the pipeline advances on that cycle.
//
// Ports:
//   clk, reset           pipeline clock, asynchronous active-high reset
//   addr_in              effective address from EX/MEM
//   store_data_in        store data (rs2) from EX/MEM
//   MemRead_in           load pending; wins over MemWrite_in if both are high
//   MemWrite_in          store pending
//   funct3_in            000 B, 001 H, 010 W, 100 BU, 101 HU, others W
//   hold_in              external stall; keeps the completed result presented in DONE
//   dmem_req             registered request valid
//   dmem_we              1 = store
//   dmem_addr            word address
//   dmem_be              byte enables
//   dmem_wdata           replicated store data
//   dmem_gnt             request accepted
//   dmem_rvalid          completion, one per granted request
//   dmem_rdata           read word
//   load_data            aligned, extended load result (registered)
//   mem_stall            combinational pipeline stall
//   misalign_fault       registered one-cycle misalignment pulse
//
// Build option: define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them.
// When it is undefined, misalign_fault is tied to 0.

module mem_access_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] addr_in,
  input  logic [XLEN-1:0] store_data_in,
  input  logic            MemRead_in,
  input  logic            MemWrite_in,
  input  logic [2:0]      funct3_in,
  input  logic            hold_in,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] load_data,
  output logic            mem_stall,
  output logic            misalign_fault
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;
  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  state_e state_q;

  // Access fields latched in IDLE so load extraction does not depend on EX/MEM later
  size_e      size_q;
  logic       unsigned_q;
  logic [1:0] lane_q;
  logic       is_load_q;

  logic            access_pending;
  logic            misaligned;
  logic            req_go;
  size_e           size_d;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d;
  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;
  logic [XLEN-1:0] rdata_ext;

  assign access_pending = MemRead_in | MemWrite_in;

  always_comb begin
    size_d = SzWord;
    if (funct3_in == 3'b000 || funct3_in == 3'b100) begin
      size_d = SzByte;
    end else if (funct3_in == 3'b001 || funct3_in == 3'b101) begin
      size_d = SzHalf;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    if (size_d == SzHalf) begin
      misaligned = addr_in[0];
    end else if (size_d == SzWord) begin
      misaligned = |addr_in[1:0];
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  assign req_go = access_pending & ~misaligned;

  assign mem_stall = ((state_q == StIdle) & req_go) | (state_q == StReq) | (state_q == StWait);

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = store_data_in;
    case (size_d)
      SzByte: begin
        be_d    = 4'b0001 << addr_in[1:0];
        wdata_d = {4{store_data_in[7:0]}};
      end
      SzHalf: begin
        be_d    = 4'b0011 << {addr_in[1], 1'b0};
        wdata_d = {2{store_data_in[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = store_data_in;
      end
    endcase
  end

  // Lane selection and extension of the returning read word
  always_comb begin
    byte_lane = dmem_rdata[7:0];
    case (lane_q)
      2'd0:    byte_lane = dmem_rdata[7:0];
      2'd1:    byte_lane = dmem_rdata[15:8];
      2'd2:    byte_lane = dmem_rdata[23:16];
      default: byte_lane = dmem_rdata[31:24];
    endcase
    half_lane = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    rdata_ext = dmem_rdata;
    case (size_q)
      SzByte: rdata_ext = unsigned_q ? {{(XLEN-8){1'b0}}, byte_lane}
                                     : {{(XLEN-8){byte_lane[7]}}, byte_lane};
      SzHalf: rdata_ext = unsigned_q ? {{(XLEN-16){1'b0}}, half_lane}
                                     : {{(XLEN-16){half_lane[15]}}, half_lane};
      default: rdata_ext = dmem_rdata;
    endcase
  end

`ifndef MISALIGN_TRAP_EN
  assign misalign_fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= 4'b0000;
      dmem_wdata <= '0;
      load_data  <= '0;
      size_q     <= SzWord;
      unsigned_q <= 1'b0;
      lane_q     <= 2'b00;
      is_load_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_fault <= 1'b0;
`endif
    end else begin
`ifdef MISALIGN_TRAP_EN
      // Pulses only for the cycle the misaligned access sits in IDLE
      misalign_fault <= (state_q == StIdle) & access_pending & misaligned;
`endif
      case (state_q)
        StIdle: begin
          if (req_go) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWrite_in & ~MemRead_in;
            dmem_addr  <= {addr_in[XLEN-1:2], 2'b00};
            dmem_be    <= be_d;
            dmem_wdata <= wdata_d;
            size_q     <= size_d;
            unsigned_q <= funct3_in[2];
            lane_q     <= addr_in[1:0];
            is_load_q  <= MemRead_in;
            state_q    <= StReq;
          end
        end
        StReq: begin
          // An rvalid coincident with the grant is not counted as completion
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            state_q  <= StWait;
          end
        end
        StWait: begin
          if (dmem_rvalid) begin
            if (is_load_q) begin
              load_data <= rdata_ext;
            end
            state_q <= StDone;
          end
        end
        StDone: begin
          if (!hold_in) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized accesses with random
// grant/response latencies and hold lengths, checked against an arithmetic reference model.

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic [2:0]  funct3_in;
  logic        hold_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] load_data;
  logic        mem_stall;
  logic        misalign_fault;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_ld = 32'h0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .addr_in       (addr_in),
    .store_data_in (store_data_in),
    .MemRead_in    (MemRead_in),
    .MemWrite_in   (MemWrite_in),
    .funct3_in     (funct3_in),
    .hold_in       (hold_in),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_gnt      (dmem_gnt),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .load_data     (load_data),
    .mem_stall     (mem_stall),
    .misalign_fault(misalign_fault)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Access size in bytes
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  // Byte offset of the naturally aligned lane group that holds the access
  function automatic int lane_off(input logic [2:0] f3, input logic [31:0] a);
    int off;
    int sz;
    off = int'(a % 4);
    sz  = size_of(f3);
    return off - (off % sz);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = size_of(f3);
    return 4'(((1 << sz) - 1) << lane_off(f3, a));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [63:0] mask;
    logic [63:0] res;
    int sz;
    sz   = size_of(f3);
    mask = (64'd1 << (8 * sz)) - 64'd1;
    res  = 64'd0;
    for (int k = 0; k < 4; k += sz) res = res | ((64'(wd) & mask) << (8 * k));
    return res[31:0];
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [63:0] mask;
    logic [63:0] v;
    int sz;
    sz   = size_of(f3);
    mask = (64'd1 << (8 * sz)) - 64'd1;
    v    = (64'(rd) >> (8 * lane_off(f3, a))) & mask;
    if ((f3 == 3'b000 || f3 == 3'b001) && v[8 * sz - 1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return (int'(a % 4) % size_of(f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdw,
                            input int gd, input int rvd, input int hd, input bit both);
    int stalls;
    logic ewe;
    logic [3:0] ebe;
    logic [31:0] ewd;
    stalls = 0;
    ewe    = wr & ~rd;
    ebe    = model_be(f3, a);
    ewd    = model_wdata(f3, wd);
    @(posedge clk); #1;
    MemRead_in = rd; MemWrite_in = wr; funct3_in = f3; addr_in = a; store_data_in = wd;
    hold_in = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1;
    if (model_misaligned(f3, a)) begin
      check_eq("trap_stall", 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
      MemRead_in = 1'b0; MemWrite_in = 1'b0;
      #1;
      check_eq("trap_fault", 32'(misalign_fault), 32'd1);
      check_eq("trap_req", 32'(dmem_req), 32'd0);
      @(posedge clk); #2;
      check_eq("trap_fault_clr", 32'(misalign_fault), 32'd0);
      check_eq("trap_req2", 32'(dmem_req), 32'd0);
      check_eq("trap_load_data", load_data, model_ld);
      return;
    end
    check_eq("idle_stall", 32'(mem_stall), 32'd1);
    check_eq("idle_req", 32'(dmem_req), 32'd0);
    if (mem_stall) stalls++;
    for (int i = 0; i <= gd; i++) begin
      @(posedge clk); #1;
      check_eq("req", 32'(dmem_req), 32'd1);
      check_eq("we", 32'(dmem_we), 32'(ewe));
      check_eq("addr", dmem_addr, a & 32'hFFFF_FFFC);
      check_eq("be", 32'(dmem_be), 32'(ebe));
      if (ewe) check_eq("wdata", dmem_wdata, ewd);
      if (mem_stall) stalls++;
      dmem_gnt    = (i == gd);
      dmem_rvalid = both && (i == gd);
      dmem_rdata  = $urandom;
    end
    for (int j = 0; j <= rvd; j++) begin
      @(posedge clk); #1;
      check_eq("wait_req", 32'(dmem_req), 32'd0);
      if (mem_stall) stalls++;
      dmem_gnt    = (j < rvd) ? 1'($urandom % 2) : 1'b0;
      dmem_rvalid = (j == rvd);
      dmem_rdata  = (j == rvd) ? rdw : $urandom;
    end
    if (rd) model_ld = model_load(f3, a, rdw);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0; dmem_gnt = 1'b0; dmem_rdata = $urandom; hold_in = (hd > 0);
    #1;
    check_eq("done_stall", 32'(mem_stall), 32'd0);
    check_eq("done_req", 32'(dmem_req), 32'd0);
    check_eq("load_data", load_data, model_ld);
    check_eq("stall_cycles", 32'(stalls), 32'(3 + gd + rvd));
    for (int k = 0; k < hd; k++) begin
      @(posedge clk); #1;
      hold_in  = (k + 1 < hd);
      dmem_gnt = 1'($urandom % 2);
      #1;
      check_eq("hold_stall", 32'(mem_stall), 32'd0);
      check_eq("hold_req", 32'(dmem_req), 32'd0);
      check_eq("hold_load_data", load_data, model_ld);
    end
    @(posedge clk); #1;
    dmem_gnt = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0; hold_in = 1'b0;
    #1;
    check_eq("after_stall", 32'(mem_stall), 32'd0);
    check_eq("after_req", 32'(dmem_req), 32'd0);
  endtask

  // Assert reset while an LW sits in REQ or WAIT; outputs must clear without a clock edge
  task automatic reset_mid(input bit in_wait);
    @(posedge clk); #1;
    MemRead_in = 1'b1; MemWrite_in = 1'b0; funct3_in = 3'b010; addr_in = 32'h300;
    @(posedge clk); #1;
    check_eq("rst_pre_req", 32'(dmem_req), 32'd1);
    if (in_wait) begin
      dmem_gnt = 1'b1;
      @(posedge clk); #1;
      dmem_gnt = 1'b0;
    end
    #1;
    reset = 1'b1;
    #1;
    model_ld = 32'h0;
    check_eq("rst_req", 32'(dmem_req), 32'd0);
    check_eq("rst_load_data", load_data, model_ld);
    check_eq("rst_be", 32'(dmem_be), 32'd0);
    check_eq("rst_idle_stall", 32'(mem_stall), 32'd1);
    MemRead_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_eq("rst_stall_clr", 32'(mem_stall), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    addr_in = '0; store_data_in = '0; MemRead_in = 1'b0; MemWrite_in = 1'b0;
    funct3_in = 3'b010; hold_in = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    @(posedge clk); @(posedge clk); #1;
    check_eq("reset_req", 32'(dmem_req), 32'd0);
    check_eq("reset_we", 32'(dmem_we), 32'd0);
    check_eq("reset_addr", dmem_addr, 32'd0);
    check_eq("reset_be", 32'(dmem_be), 32'd0);
    check_eq("reset_wdata", dmem_wdata, 32'd0);
    check_eq("reset_load_data", load_data, 32'd0);
    check_eq("reset_fault", 32'(misalign_fault), 32'd0);
    check_eq("reset_stall", 32'(mem_stall), 32'd0);
    reset = 1'b0;

    // Directed cases
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, 1'b0);
    check_eq("lw_value", load_data, 32'hDEADBEEF);
    run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 0, 1'b0);
    check_eq("lb_value", load_data, 32'hFFFFFF80);
    run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 0, 1'b0);
    check_eq("lbu_value", load_data, 32'h00000080);
    run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 3, 0, 0, 1'b0);
    check_eq("sh_keeps_load", load_data, 32'h00000080);
    run_access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 0, 0, 2, 1'b0);
    run_access(1'b1, 1'b1, 3'b101, 32'h106, 32'h55555555, 32'h8001_7FFF, 1, 2, 1, 1'b1);
    run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h01020304, 0, 0, 0, 1'b0);
    reset_mid(1'b1);
    reset_mid(1'b0);

    // Randomized accesses
    for (int n = 0; n < 200; n++) begin
      int kind;
      kind = int'($urandom % 3);
      run_access(kind != 1, kind != 0, 3'($urandom % 8), $urandom, $urandom, $urandom,
                 int'($urandom % 4), int'($urandom % 4), int'($urandom % 3),
                 1'($urandom % 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
